// File: rtl/mult_pkg.sv
// Shared sizing defaults and helpers for the limb-decomposed multiplier.
// Holds operand/limb defaults plus limb-count and accumulator-width helpers.
package mult_pkg;

    localparam int W_A_DEF   = 25;
    localparam int W_B_DEF   = 25;
    localparam int LIMB_DEF  = 12;
    localparam int GUARD_DEF = 8;

    // Number of LIMB-bit pieces needed to cover a wa-bit operand.
    function automatic int nl_calc(input int wa, input int limb);
        return (wa + limb - 1) / limb;
    endfunction

    function automatic int acc_w_calc(input int wa, input int wb, input int g);
        return wa + wb + g;
    endfunction

    localparam int ACC_W_DEF = acc_w_calc(W_A_DEF, W_B_DEF, GUARD_DEF);

endpackage

// File: rtl/mult_limb.sv
// Registered signed AW x BW partial multiplier with clock enable (one DSP).
// Ports: clk, rst (async high), ce, a_i, b_i (signed) -> p_o (registered).
module mult_limb #(
    parameter int AW = 13,
    parameter int BW = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic signed [AW-1:0] a_i,
    input  logic signed [BW-1:0] b_i,
    output logic signed [AW+BW-1:0] p_o
);

    logic signed [AW+BW-1:0] p_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
        end else if (ce) begin
            p_q <= a_i * b_i;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/mult_core_param.sv
// Three-stage pipelined W_A x W_B multiplier with optional accumulate.
// Ports: clk, rst, in_valid, din_a, din_b, is_signed, acc_en, acc_clr,
//        stall -> dout (ACC_W bits), out_valid.
module mult_core_param
    import mult_pkg::*;
#(
    parameter int W_A   = W_A_DEF,
    parameter int W_B   = W_B_DEF,
    parameter int LIMB  = LIMB_DEF,
    parameter int GUARD = GUARD_DEF,
    localparam int ACC_W = acc_w_calc(W_A, W_B, GUARD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W_A-1:0]   din_a,
    input  logic [W_B-1:0]   din_b,
    input  logic             is_signed,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic             stall,
    output logic [ACC_W-1:0] dout,
    output logic             out_valid
);

    localparam int NL  = nl_calc(W_A, LIMB);
    localparam int APW = NL * LIMB;
    localparam int PW  = LIMB + W_B + 2;
    localparam int SW  = (ACC_W > PW) ? ACC_W : PW;

    logic en;
    assign en = ~stall;

    // S1: operands and mode bits
    logic [W_A-1:0] a_q;
    logic [W_B-1:0] b_q;
    logic           v1_q, sgn1_q, acc1_q, clr1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            v1_q   <= 1'b0;
            sgn1_q <= 1'b0;
            acc1_q <= 1'b0;
            clr1_q <= 1'b0;
        end else if (en) begin
            a_q    <= din_a;
            b_q    <= din_b;
            v1_q   <= in_valid;
            sgn1_q <= is_signed;
            acc1_q <= acc_en;
            clr1_q <= acc_clr;
        end
    end

    // A padded to whole limbs; the pad follows the mode so a short top
    // limb still carries the correct sign.
    logic [APW-1:0]   a_pad;
    logic signed [W_B:0] b_ext;

    always_comb begin
        if (sgn1_q) a_pad = APW'($signed(a_q));
        else        a_pad = APW'(a_q);
    end

    assign b_ext = {sgn1_q & b_q[W_B-1], b_q};

    // S2: limb products (registered inside mult_limb)
    logic signed [PW-1:0] p_arr [NL];

    for (genvar gi = 0; gi < NL; gi++) begin : g_limb
        logic signed [LIMB:0] la;
        // Only the top limb is signed; lower limbs are magnitude pieces.
        if (gi == NL - 1) begin : g_top
            assign la = {sgn1_q & a_pad[APW-1], a_pad[gi*LIMB +: LIMB]};
        end else begin : g_low
            assign la = {1'b0, a_pad[gi*LIMB +: LIMB]};
        end
        mult_limb #(
            .AW (LIMB + 1),
            .BW (W_B + 1)
        ) u_limb (
            .clk (clk),
            .rst (rst),
            .ce  (en),
            .a_i (la),
            .b_i (b_ext),
            .p_o (p_arr[gi])
        );
    end

    logic v2_q, acc2_q, clr2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            acc2_q <= 1'b0;
            clr2_q <= 1'b0;
        end else if (en) begin
            v2_q   <= v1_q;
            acc2_q <= acc1_q;
            clr2_q <= clr1_q;
        end
    end

    // Sign-extended partials summed modulo 2^SW give ext(P) exactly.
    logic [SW-1:0]    sum;
    logic [ACC_W-1:0] prod;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NL; i++) begin
            sum = sum + (SW'(p_arr[i]) << (i * LIMB));
        end
    end

    assign prod = sum[ACC_W-1:0];

    // S3: result and accumulator
    logic [ACC_W-1:0] acc_q, acc_d, dout_q, dout_d;
    logic             ov_q;

    always_comb begin
        acc_d  = acc_q;
        dout_d = dout_q;
        if (v2_q) begin
            if (acc2_q) begin
                acc_d  = clr2_q ? prod : acc_q + prod;
                dout_d = acc_d;
            end else begin
                dout_d = prod;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            dout_q <= '0;
            ov_q   <= 1'b0;
        end else if (en) begin
            acc_q  <= acc_d;
            dout_q <= dout_d;
            ov_q   <= v2_q;
        end
    end

    assign dout      = dout_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_mult_core_param.sv
// Bench for mult_core_param: directed cases plus a two-config parameter
// sweep, all checked through per-DUT expected-result queues.
module tb_mult_core_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv0, s0, e0, c0, st0, ov0;
    logic [24:0] a0, b0;
    logic [57:0] d0;

    logic        iv1, s1, e1, c1, st1, ov1;
    logic [16:0] a1;
    logic [14:0] b1;
    logic [39:0] d1;

    logic        iv2, s2, e2, c2, st2, ov2;
    logic [31:0] a2, b2;
    logic [71:0] d2;

    int errors = 0;
    int checks = 0;
    bit stalled = 1'b0;

    logic [127:0] q0[$], q1[$], q2[$];
    logic [127:0] acc_m0 = '0, acc_m1 = '0, acc_m2 = '0;

    mult_core_param u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .din_a(a0), .din_b(b0),
        .is_signed(s0), .acc_en(e0), .acc_clr(c0), .stall(st0),
        .dout(d0), .out_valid(ov0)
    );

    mult_core_param #(.W_A(17), .W_B(15), .LIMB(8), .GUARD(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .din_a(a1), .din_b(b1),
        .is_signed(s1), .acc_en(e1), .acc_clr(c1), .stall(st1),
        .dout(d1), .out_valid(ov1)
    );

    mult_core_param #(.W_A(32), .W_B(32), .LIMB(12), .GUARD(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .din_a(a2), .din_b(b2),
        .is_signed(s2), .acc_en(e2), .acc_clr(c2), .stall(st2),
        .dout(d2), .out_valid(ov2)
    );

    function automatic logic [127:0] mask(input int w);
        return (128'd1 << w) - 128'd1;
    endfunction

    function automatic logic [127:0] ref_prod(input logic [63:0] a,
        input logic [63:0] b, input bit sg, input int wa, input int wb);
        logic [127:0] sa, sb;
        sa = {64'd0, a} & mask(wa);
        sb = {64'd0, b} & mask(wb);
        if (sg && a[wa-1]) sa = sa | ~mask(wa);
        if (sg && b[wb-1]) sb = sb | ~mask(wb);
        return sa * sb;
    endfunction

    task automatic model(input int id, input logic [63:0] a, input logic [63:0] b,
                         input bit sg, input bit en, input bit cl);
        int wa, wb, cw;
        logic [127:0] p, acc, r;
        if (id == 0) begin wa = 25; wb = 25; cw = 58; acc = acc_m0; end
        else if (id == 1) begin wa = 17; wb = 15; cw = 40; acc = acc_m1; end
        else begin wa = 32; wb = 32; cw = 72; acc = acc_m2; end
        p = ref_prod(a, b, sg, wa, wb) & mask(cw);
        if (en) begin
            acc = cl ? p : (acc + p) & mask(cw);
            r = acc;
        end else begin
            r = p;
        end
        if (id == 0) begin acc_m0 = acc; q0.push_back(r); end
        else if (id == 1) begin acc_m1 = acc; q1.push_back(r); end
        else begin acc_m2 = acc; q2.push_back(r); end
    endtask

    task automatic step0(input logic v, input logic [24:0] a, input logic [24:0] b,
                         input logic sg, input logic en, input logic cl, input logic st);
        iv0 = v; a0 = a; b0 = b; s0 = sg; e0 = en; c0 = cl; st0 = st;
        @(posedge clk);
        #1;
        stalled = st;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv0 = 0; a0 = 0; b0 = 0; s0 = 0; e0 = 0; c0 = 0; st0 = 0;
        iv1 = 0; a1 = 0; b1 = 0; s1 = 0; e1 = 0; c1 = 0; st1 = 0;
        iv2 = 0; a2 = 0; b2 = 0; s2 = 0; e2 = 0; c2 = 0; st2 = 0;
        #12;
        checks++;
        if (ov0 !== 1'b0 || d0 !== 58'd0) begin
            errors++;
            $display("FAIL reset_dut0: ov=%b dout=%h, want ov=0 dout=0", ov0, d0);
        end
        checks++;
        if (ov1 !== 1'b0 || d1 !== 40'd0 || ov2 !== 1'b0 || d2 !== 72'd0) begin
            errors++;
            $display("FAIL reset_sweep: ov1=%b d1=%h ov2=%b d2=%h, want zeros",
                     ov1, d1, ov2, d2);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_unsigned_max();
        int lat;
        logic [127:0] exp;
        q0.push_back(128'(58'h3FFFFFC000001));
        step0(1, 25'h1FFFFFF, 25'h1FFFFFF, 0, 0, 0, 0);
        lat = 1;
        while (!ov0 && lat < 8) begin
            step0(0, 0, 0, 0, 0, 0, 0);
            lat++;
        end
        checks++;
        if (!ov0 || lat != 3) begin
            errors++;
            $display("FAIL umax_latency: ov=%b after %0d cycles, want ov=1 after 3", ov0, lat);
        end
        exp = q0.pop_front();
        checks++;
        if (d0 !== exp[57:0]) begin
            errors++;
            $display("FAIL umax_value: dout=%h, want %h", d0, exp[57:0]);
        end
        step0(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ov0 !== 1'b0 || d0 !== exp[57:0]) begin
            errors++;
            $display("FAIL umax_hold: ov=%b dout=%h, want ov=0 dout=%h", ov0, d0, exp[57:0]);
        end
    endtask

    task automatic test_signed();
        logic [127:0] exp;
        q0.push_back(128'(58'h1000000));
        q0.push_back(128'(58'h3FFFFFFFFFFFFFD));
        for (int k = 0; k < 10; k++) begin
            if (k == 0) step0(1, 25'h1FFFFFF, 25'h1000000, 1, 0, 0, 0);
            else if (k == 1) step0(1, 25'h1FFFFFF, 25'h0000003, 1, 0, 0, 0);
            else step0(0, 0, 0, 0, 0, 0, 0);
            if (ov0 && !stalled) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL signed_extra: dout=%h, want no output", d0);
                end else begin
                    exp = q0.pop_front();
                    if (d0 !== exp[57:0]) begin
                        errors++;
                        $display("FAIL signed_value: dout=%h, want %h", d0, exp[57:0]);
                    end
                end
            end
        end
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL signed_missing: %0d outstanding, want 0", q0.size());
            q0.delete();
        end
    endtask

    task automatic test_accumulate();
        logic [24:0] ta[5] = '{100, 300, 5, 7, 1};
        logic [24:0] tb[5] = '{200, 400, 6, 8, 1};
        bit te[5] = '{1, 1, 1, 0, 1};
        bit tc[5] = '{1, 0, 0, 0, 0};
        logic [57:0] tx[5] = '{20000, 140000, 140030, 56, 140031};
        int n;
        logic [127:0] exp;
        n = 0;
        for (int i = 0; i < 5; i++) q0.push_back(128'(tx[i]));
        for (int k = 0; k < 12; k++) begin
            if (k < 5) step0(1, ta[k], tb[k], 0, te[k], tc[k], 0);
            else step0(0, 0, 0, 0, 0, 0, 0);
            if (ov0 && !stalled) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL acc_extra: dout=%h, want no output", d0);
                end else begin
                    exp = q0.pop_front();
                    if (d0 !== exp[57:0] || k != n + 2) begin
                        errors++;
                        $display("FAIL acc_value: dout=%0d at cycle %0d, want %0d at cycle %0d",
                                 d0, k, exp[57:0], n + 2);
                    end
                    n++;
                end
            end
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL acc_count: got %0d outputs, want 5", n);
            q0.delete();
        end
    endtask

    task automatic test_stall();
        logic [57:0] hold_d;
        logic hold_ov;
        logic [127:0] exp;
        int n;
        n = 0;
        hold_d = '0;
        hold_ov = 1'b0;
        q0.push_back(128'd15);
        q0.push_back(128'd77);
        q0.push_back(128'd221);
        for (int k = 0; k < 12; k++) begin
            if (k == 3) begin hold_d = d0; hold_ov = ov0; end
            if (k == 0) step0(1, 3, 5, 0, 0, 0, 0);
            else if (k == 1) step0(1, 7, 11, 0, 0, 0, 0);
            else if (k == 2) step0(1, 13, 17, 0, 0, 0, 0);
            else if (k == 3 || k == 4) step0(1, 999, 999, 0, 0, 0, 1);
            else step0(0, 0, 0, 0, 0, 0, 0);
            if (k == 3 || k == 4) begin
                checks++;
                if (d0 !== hold_d || ov0 !== hold_ov) begin
                    errors++;
                    $display("FAIL stall_freeze: ov=%b dout=%h, want ov=%b dout=%h",
                             ov0, d0, hold_ov, hold_d);
                end
            end
            if (ov0 && !stalled) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra: dout=%h, want no output", d0);
                end else begin
                    exp = q0.pop_front();
                    n++;
                    if (d0 !== exp[57:0]) begin
                        errors++;
                        $display("FAIL stall_value: dout=%0d, want %0d", d0, exp[57:0]);
                    end
                end
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL stall_count: got %0d outputs, want 3", n);
            q0.delete();
        end
    endtask

    task automatic test_reset_midflight();
        logic [127:0] exp;
        int stale;
        stale = 0;
        step0(1, 11, 12, 0, 1, 0, 0);
        step0(1, 13, 14, 0, 1, 0, 0);
        step0(1, 15, 16, 0, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ov0 !== 1'b0 || d0 !== 58'd0) begin
            errors++;
            $display("FAIL midreset_clear: ov=%b dout=%h, want ov=0 dout=0", ov0, d0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step0(0, 0, 0, 0, 0, 0, 0);
            if (ov0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midreset_stale: %0d stale outputs, want 0", stale);
        end
        q0.push_back(128'd6);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) step0(1, 2, 3, 0, 1, 0, 0);
            else step0(0, 0, 0, 0, 0, 0, 0);
            if (ov0 && !stalled) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL midreset_extra: dout=%h, want no output", d0);
                end else begin
                    exp = q0.pop_front();
                    if (d0 !== exp[57:0]) begin
                        errors++;
                        $display("FAIL midreset_acc: dout=%0d, want %0d", d0, exp[57:0]);
                    end
                end
            end
        end
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL midreset_missing: %0d outstanding, want 0", q0.size());
            q0.delete();
        end
    endtask

    function automatic logic [63:0] pick(input int w);
        int r;
        logic [63:0] v;
        r = $urandom_range(0, 7);
        if (r == 0) v = mask(w)[63:0];
        else if (r == 1) v = 64'd1 << (w - 1);
        else if (r == 2) v = 64'd0;
        else v = {$urandom, $urandom};
        return v & mask(w)[63:0];
    endfunction

    task automatic test_random_main();
        logic v, sg, en, cl, st;
        logic [63:0] a, b;
        logic [127:0] exp;
        for (int k = 0; k < 820; k++) begin
            v  = (k < 800) && ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 7) == 0);
            sg = $urandom_range(0, 1);
            en = $urandom_range(0, 1);
            cl = (k == 0) || ($urandom_range(0, 5) == 0);
            a  = pick(25);
            b  = pick(25);
            if (k == 0) begin v = 1; st = 0; en = 1; end
            if (v && !st) model(0, a, b, sg, en, cl);
            step0(v, a[24:0], b[24:0], sg, en, cl, st);
            if (ov0 && !stalled) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: dout=%h, want no output", d0);
                end else begin
                    exp = q0.pop_front();
                    if (d0 !== exp[57:0]) begin
                        errors++;
                        $display("FAIL rand_value: dout=%h, want %h", d0, exp[57:0]);
                    end
                end
            end
        end
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL rand_missing: %0d outstanding, want 0", q0.size());
            q0.delete();
        end
    endtask

    task automatic test_param_sweep();
        bit sd1, sd2;
        logic [63:0] a, b;
        logic [127:0] exp;
        for (int k = 0; k < 10020; k++) begin
            iv1 = (k < 10000) && ($urandom_range(0, 4) != 0);
            st1 = ($urandom_range(0, 9) == 0);
            s1 = $urandom_range(0, 1);
            e1 = $urandom_range(0, 1);
            c1 = (k == 0) || ($urandom_range(0, 7) == 0);
            a = pick(17); b = pick(15);
            a1 = a[16:0]; b1 = b[14:0];
            if (iv1 && !st1) model(1, a, b, s1, e1, c1);
            iv2 = (k < 10000) && ($urandom_range(0, 4) != 0);
            st2 = ($urandom_range(0, 9) == 0);
            s2 = $urandom_range(0, 1);
            e2 = $urandom_range(0, 1);
            c2 = (k == 0) || ($urandom_range(0, 7) == 0);
            a = pick(32); b = pick(32);
            a2 = a[31:0]; b2 = b[31:0];
            if (iv2 && !st2) model(2, a, b, s2, e2, c2);
            sd1 = st1;
            sd2 = st2;
            @(posedge clk);
            #1;
            if (ov1 && !sd1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL sweep17_extra: dout=%h, want no output", d1);
                end else begin
                    exp = q1.pop_front();
                    if (d1 !== exp[39:0]) begin
                        errors++;
                        $display("FAIL sweep17_value: dout=%h, want %h", d1, exp[39:0]);
                    end
                end
            end
            if (ov2 && !sd2) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL sweep32_extra: dout=%h, want no output", d2);
                end else begin
                    exp = q2.pop_front();
                    if (d2 !== exp[71:0]) begin
                        errors++;
                        $display("FAIL sweep32_value: dout=%h, want %h", d2, exp[71:0]);
                    end
                end
            end
        end
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL sweep_missing: %0d/%0d outstanding, want 0/0",
                     q1.size(), q2.size());
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_accumulate();
        test_stall();
        test_reset_midflight();
        test_random_main();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_core_param.md
Name: mult_core_param

Overview:
- Parametrised, fully pipelined W_A x W_B integer multiplier built from LIMB-bit partial products, each sized for one DSP slice.
- Supports unsigned or signed operands selected per transaction, and an optional multiply-accumulate mode.
- Adds stall and valid tracking to the pipeline.
- Sits in the NTT/polynomial arithmetic datapath, feeding modular-reduction stages.

Parameters:
- W_A, 25, width of operand A (split into limbs)
- W_B, 25, width of operand B (full width into every partial multiplier)
- LIMB, 12, limb width of A; NL = ceil(W_A/LIMB) partial products
- GUARD, 8, accumulator guard bits; ACC_W = W_A+W_B+GUARD

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid this cycle
- din_a  in  W_A  operand A
- din_b  in  W_B  operand B
- is_signed  in  1  1: two's-complement operands; 0: unsigned; sampled with in_valid
- acc_en  in  1  1: add product into accumulator; sampled with in_valid
- acc_clr  in  1  1: accumulator restarts from this product (ignored unless acc_en)
- stall  in  1  freeze entire pipeline, all registers hold
- dout  out  ACC_W  result
- out_valid  out  1  dout valid this cycle

Behaviour:
- Reset: rst is asynchronous and active-high. Clears all valid bits, the accumulator, dout=0 and out_valid=0. Reset mid-operation discards all in-flight transactions.
- Pipeline, 3 stages, latency 3 cycles (excluding stall cycles):
  - S1 registers operands, mode bits and valid.
  - S2 registers NL limb products, each (LIMB+1)x(W_B+1) signed.
  - S3 registers the shifted sum, or the accumulator update, into dout.
- Throughput: 1 transaction per cycle.
- out_valid is the S3 valid bit. dout holds its last value while out_valid=0.
- stall=1: no register changes (valid bits included); in_valid is ignored that cycle; out_valid and dout hold. A transaction presented during stall is lost; the upstream block must hold it.
- Arithmetic, exact product P of W_A+W_B bits:
  - Unsigned: every limb zero-extended; B zero-extended.
  - Signed: top limb of A sign-extended, lower limbs zero-extended; B sign-extended. The sum is bit-exact two's complement.
  - The last limb may be shorter than LIMB. It is padded according to the mode.
- Non-accumulate (acc_en=0): dout = P extended to ACC_W (sign-extended if is_signed, else zero-extended). The accumulator is not updated.
- Accumulate (acc_en=1):
  - acc_clr=1: acc = ext(P).
  - acc_clr=0: acc = acc + ext(P), modulo 2^ACC_W (wraps, no saturation, no overflow flag).
  - dout = new acc.
- Interleaving acc_en=0 transactions between accumulate ones leaves acc untouched.
- Mode bits travel with their transaction; mixing modes back-to-back is legal.
- Bubbles (in_valid=0) advance through the pipeline with valid=0 and never touch the accumulator.

Decomposition:
- Package mult_pkg:
  - default W_A/W_B/LIMB/GUARD
  - NL computation function
  - ACC_W localparam helper
- One natural sub-module: mult_limb, a registered (LIMB+1)x(W_B+1) signed multiplier with clock enable. It is instantiated NL times and maps to one DSP each.
- Shift/sum and the accumulator stay in the top level.

Test Plan:
- Unsigned max: din_a=0x1FFFFFF, din_b=0x1FFFFFF, is_signed=0, acc_en=0 -> 3 cycles later out_valid=1, dout=0x3FFFFFC000001.
- Signed: din_a=0x1FFFFFF (-1), din_b=0x1000000 (-2^24), is_signed=1 -> dout=0x1000000. Then din_a=0x1FFFFFF, din_b=0x0000003 -> dout=-3 sign-extended to ACC_W (all ones ...FFFD).
- Accumulate: (100,200,clr=1), (300,400,clr=0), (5,6,clr=0) on consecutive cycles -> dout=20000, 140000, 140030 on 3 consecutive cycles. Then (7,8,acc_en=0) -> dout=56, and next (1,1,acc_en=1,clr=0) -> 140031.
- Stall: issue 3 back-to-back products, assert stall for 2 cycles at cycle 2 -> outputs appear in order with a 2-cycle gap, none lost or duplicated, dout/out_valid frozen during stall.
- Reset mid-flight: issue 2 transactions, assert rst asynchronously between edges -> out_valid=0 and dout=0 immediately. After release, no stale outputs appear; the next accumulate with clr=0 starts from acc=0.
- Parameter sweep: W_A=17, LIMB=8 (short top limb), and W_A=W_B=32 with random signed/unsigned operands over 10k transactions -> bit-exact against reference model.
